// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - handshake bundle between ALU, result stage and writeback
interface alu_result_stage_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_zero;
    logic             in_neg;
    logic [2:0]       in_dest;
    logic             in_setflags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_dest;

    // ALU/writeback side
    modport master (
        output in_valid, in_result, in_carry, in_zero, in_neg, in_dest, in_setflags, out_ready,
        input  in_ready, out_valid, out_result, out_dest
    );

    // result stage side
    modport slave (
        input  in_valid, in_result, in_carry, in_zero, in_neg, in_dest, in_setflags, out_ready,
        output in_ready, out_valid, out_result, out_dest
    );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry result FIFO with architectural flags and op counter
module alu_result_stage #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_stage_if.slave  bus,
    output logic               flag_c,
    output logic               flag_z,
    output logic               flag_n,
    output logic               carry_fb,
    output logic [7:0]         op_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] head_result;
    logic [2:0]       head_dest;
    logic [WIDTH-1:0] tail_result;
    logic [2:0]       tail_dest;

    logic push;
    logic pop;

    // handshakes use only registered ready/valid, so no out_ready -> in_ready path exists
    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = head_result;
    assign bus.out_dest   = head_dest;
    assign carry_fb       = flag_c;

    // FIFO state machine; head is kept in the output registers, tail holds the second entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_result <= '0;
            head_dest   <= '0;
            tail_result <= '0;
            tail_dest   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_result <= bus.in_result;
                        head_dest   <= bus.in_dest;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_result <= bus.in_result;
                        head_dest   <= bus.in_dest;
                    end else if (push) begin
                        tail_result <= bus.in_result;
                        tail_dest   <= bus.in_dest;
                        in_ready_q  <= 1'b0;
                        state       <= FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_result <= tail_result;
                        head_dest   <= tail_dest;
                        in_ready_q  <= 1'b1;
                        state       <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // flags follow the accepted op at push time, only when it asks to set them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (push && bus.in_setflags) begin
            flag_c <= bus.in_carry;
            flag_z <= bus.in_zero;
            flag_n <= bus.in_neg;
        end
    end

    // saturating count of accepted operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 8'h00;
        end else if (push && (op_count != 8'hFF)) begin
            op_count <= op_count + 8'h01;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized and directed bench for alu_result_stage
module tb_alu_result_stage;
    localparam int WIDTH = 8;

    logic       clk;
    logic       rst;
    logic       flag_c, flag_z, flag_n, carry_fb;
    logic [7:0] op_count;

    int checks;
    int failures;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .carry_fb (carry_fb),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: a queue of {result,dest}, flags and a saturating counter
    logic [10:0] mq[$];
    logic        m_c, m_z, m_n;
    int          m_count;
    int          m_pops;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
            m_count = 0;
        end else begin
            automatic bit do_push = bus.in_valid && (mq.size() < 2);
            automatic bit do_pop  = bus.out_ready && (mq.size() > 0);
            if (do_pop) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (do_push) begin
                mq.push_back({bus.in_result, bus.in_dest});
                if (bus.in_setflags) begin
                    m_c = bus.in_carry; m_z = bus.in_zero; m_n = bus.in_neg;
                end
                if (m_count < 255) m_count++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle outside reset, DUT must agree with the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
            chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
            if (mq.size() > 0) begin
                chk("m_head", {21'd0, bus.out_result, bus.out_dest}, {21'd0, mq[0]});
            end
            chk("m_flags", {28'd0, flag_c, flag_z, flag_n, carry_fb}, {28'd0, m_c, m_z, m_n, m_c});
            chk("m_op_count", {24'd0, op_count}, m_count);
        end
    end

    task automatic drive(input logic v, input logic [7:0] res, input logic c, input logic z,
                         input logic n, input logic [2:0] d, input logic sf, input logic ordy);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_carry    = c;
        bus.in_zero     = z;
        bus.in_neg      = n;
        bus.in_dest     = d;
        bus.in_setflags = sf;
        bus.out_ready   = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_pops = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_carry = 0; bus.in_zero = 0;
        bus.in_neg = 0; bus.in_dest = '0; bus.in_setflags = 0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_result", {24'd0, bus.out_result}, 32'd0);
        chk("rst_out_dest", {29'd0, bus.out_dest}, 32'd0);
        chk("rst_flags", {28'd0, flag_c, flag_z, flag_n, carry_fb}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        rst = 1'b0;

        // single op
        drive(1, 8'h0F, 1, 0, 0, 3'd3, 1, 1);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_result", {24'd0, bus.out_result}, 32'h0F);
        chk("single_dest", {29'd0, bus.out_dest}, 32'd3);
        chk("single_flag_c", {31'd0, flag_c}, 32'd1);
        chk("single_carry_fb", {31'd0, carry_fb}, 32'd1);
        chk("single_op_count", {24'd0, op_count}, 32'd1);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);

        // backpressure
        do_reset();
        drive(1, 8'h11, 0, 0, 0, 3'd1, 0, 0);
        drive(1, 8'h22, 0, 0, 0, 3'd2, 0, 0);
        chk("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1, 8'h33, 1, 1, 1, 3'd3, 1, 0);
        chk("bp_op_count", {24'd0, op_count}, 32'd2);
        chk("bp_flags_unchanged", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        chk("bp_head0", {24'd0, bus.out_result}, 32'h11);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);
        chk("bp_head1", {24'd0, bus.out_result}, 32'h22);
        chk("bp_head1_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // simultaneous push and pop in ONE
        do_reset();
        drive(1, 8'hAA, 0, 0, 0, 3'd5, 0, 0);
        chk("pp_head_aa", {24'd0, bus.out_result}, 32'hAA);
        drive(1, 8'hBB, 0, 0, 0, 3'd6, 0, 1);
        chk("pp_head_bb", {24'd0, bus.out_result}, 32'hBB);
        chk("pp_one_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pp_one_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);

        // flag gating
        do_reset();
        drive(1, 8'h01, 1, 0, 0, 3'd1, 1, 1);
        drive(1, 8'h02, 0, 1, 1, 3'd2, 0, 1);
        chk("fg_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b100);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);

        // asynchronous reset mid-operation
        do_reset();
        drive(1, 8'h44, 1, 1, 0, 3'd4, 1, 0);
        drive(1, 8'h55, 0, 0, 1, 3'd5, 1, 0);
        chk("ar_pre_count", {24'd0, op_count}, 32'd2);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ar_flags", {28'd0, flag_c, flag_z, flag_n, carry_fb}, 32'd0);
        chk("ar_op_count", {24'd0, op_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1, 8'h66, 0, 0, 0, 3'd6, 0, 0);
        chk("ar_first_push", {21'd0, bus.out_result, bus.out_dest}, {21'd0, 8'h66, 3'd6});
        chk("ar_first_count", {24'd0, op_count}, 32'd1);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);

        // saturation with continuous flow
        do_reset();
        m_pops = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), 1);
        end
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);
        chk("sat_op_count", {24'd0, op_count}, 32'hFF);
        chk("sat_delivered", m_pops, 32'd300);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 1);
        chk("rand_drained", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
